// File: rtl/key_event_ctrl_pkg.sv
// Shared definitions for the keypad event controller: key codes, FSM states, counter sizing.
package key_evt_pkg;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_0    = 4'd0;
    localparam key_code_t KEY_1    = 4'd1;
    localparam key_code_t KEY_2    = 4'd2;
    localparam key_code_t KEY_3    = 4'd3;
    localparam key_code_t KEY_4    = 4'd4;
    localparam key_code_t KEY_5    = 4'd5;
    localparam key_code_t KEY_6    = 4'd6;
    localparam key_code_t KEY_7    = 4'd7;
    localparam key_code_t KEY_8    = 4'd8;
    localparam key_code_t KEY_9    = 4'd9;
    localparam key_code_t KEY_A    = 4'd10;
    localparam key_code_t KEY_B    = 4'd11;
    localparam key_code_t KEY_C    = 4'd12;
    localparam key_code_t KEY_D    = 4'd13;
    localparam key_code_t KEY_HASH = 4'd14;
    localparam key_code_t KEY_STAR = 4'd15;

    typedef enum logic {IDLE, PRESSED} state_t;

    // Bits needed to hold any value 0..maxVal (at least one bit).
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Valid/ready event channel from the key controller to the game FSM.
interface key_event_ctrl_if;
    import key_evt_pkg::*;

    logic      evt_valid;
    key_code_t evt_code;
    logic      evt_ready;

    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface

// File: rtl/key_event_ctrl_fifo.sv
// Circular event FIFO with registered head/valid so the consumer sees no combinational paths.
module key_evt_fifo
    import key_evt_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = cntWidth(DEPTH),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  key_code_t     i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic          o_valid,
    output key_code_t     o_data,
    output logic          o_full,
    output logic [CW-1:0] o_count
);

    key_code_t     r_mem [DEPTH];
    logic [AW-1:0] r_rdPtr;
    logic [AW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    key_code_t     r_head;

    logic          w_doPush;
    logic          w_doPop;
    logic [AW-1:0] w_rdNext;
    logic [CW-1:0] w_countNext;

    assign o_full      = (r_count == CW'(DEPTH));
    assign w_doPop     = i_pop && r_valid;
    assign w_doPush    = i_push && (!o_full || w_doPop);
    assign w_rdNext    = r_rdPtr + AW'(w_doPop);
    assign w_countNext = r_count + CW'(w_doPush) - CW'(w_doPop);

    always_ff @(posedge clk) begin
        if (w_doPush && !i_flush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // The head register is preloaded with the next entry; a word written this
    // cycle into the slot that becomes the head bypasses the memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
        end else if (i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
        end else begin
            r_rdPtr <= w_rdNext;
            r_wrPtr <= r_wrPtr + AW'(w_doPush);
            r_count <= w_countNext;
            r_valid <= (w_countNext != '0);
            if (w_countNext == '0) begin
                r_head <= '0;
            end else if (w_doPush && (w_rdNext == r_wrPtr)) begin
                r_head <= i_data;
            end else begin
                r_head <= r_mem[w_rdNext];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/key_event_ctrl.sv
// Keypad scanner strobes -> one queued event per press, release by idle timeout.
// Optional auto-repeat while held is built when KEY_REPEAT_EN is defined.
module key_event_ctrl
    import key_evt_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int RELEASE_CYCLES = 250000,
    parameter int REPEAT_DELAY   = 25000000,
    parameter int REPEAT_PERIOD  = 10000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   key_en,
    input  key_code_t              key_code,
    key_event_ctrl_if.master       evt,
    output logic                   held,
    output key_code_t              held_code,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int TW = cntWidth(RELEASE_CYCLES - 1);
    localparam logic [TW-1:0] REL_LAST = TW'(RELEASE_CYCLES - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RELEASE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badParams
        $error("key_event_ctrl: illegal parameter set");
    end

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          r_held;
    key_code_t     r_heldCode;
    logic          r_overflow;

    logic          w_newPress;
    logic          w_release;
    logic          w_push;
    key_code_t     w_pushCode;
    logic          w_full;
    logic          w_valid;

    assign w_newPress = enable && key_en && ((r_state == IDLE) || (key_code != r_heldCode));
    assign w_release  = (r_state == PRESSED) && !key_en && (r_timer == REL_LAST);

`ifdef KEY_REPEAT_EN
    localparam int RW = cntWidth((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

    logic [RW-1:0] r_holdCnt;
    logic          r_rptPhase;
    logic          w_rptFire;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; the count
    // is the number of cycles since the press or the previous repeat.
    assign w_rptFire  = enable && (r_state == PRESSED) && !w_newPress && !w_release &&
                        (r_holdCnt == (r_rptPhase ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
    assign w_push     = w_newPress || w_rptFire;
    assign w_pushCode = w_newPress ? key_code : r_heldCode;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_holdCnt  <= '0;
            r_rptPhase <= 1'b0;
        end else if (w_newPress) begin
            r_holdCnt  <= RW'(1);
            r_rptPhase <= 1'b0;
        end else if (!enable || (r_state != PRESSED) || w_release) begin
            r_holdCnt  <= '0;
            r_rptPhase <= 1'b0;
        end else if (w_rptFire) begin
            r_holdCnt  <= RW'(1);
            r_rptPhase <= 1'b1;
        end else begin
            r_holdCnt  <= r_holdCnt + RW'(1);
        end
    end
`else
    assign w_push     = w_newPress;
    assign w_pushCode = key_code;
`endif

    key_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_pushCode),
        .i_pop   (evt.evt_ready),
        .i_flush (!enable),
        .o_valid (w_valid),
        .o_data  (evt.evt_code),
        .o_full  (w_full),
        .o_count (fifo_count)
    );

    assign evt.evt_valid = w_valid;

    // Scanner strobes arrive every scan while a key is down; only a code
    // change or a strobe after a release timeout counts as a new press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_held     <= 1'b0;
            r_heldCode <= '0;
        end else if (!enable) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_held     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (key_en) begin
                        r_state    <= PRESSED;
                        r_held     <= 1'b1;
                        r_heldCode <= key_code;
                        r_timer    <= '0;
                    end
                end
                PRESSED: begin
                    if (key_en) begin
                        r_heldCode <= key_code;
                        r_timer    <= '0;
                    end else if (r_timer == REL_LAST) begin
                        r_state    <= IDLE;
                        r_held     <= 1'b0;
                        r_timer    <= '0;
                    end else if (r_timer != '1) begin
                        r_timer    <= r_timer + TW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !(evt.evt_ready && w_valid)) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign held      = r_held;
    assign held_code = r_heldCode;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with release/repeat timing scaled down (RELEASE_CYCLES=1000).
module tb_key_event_ctrl;
    import key_evt_pkg::*;

    localparam int DEPTH = 4;
    localparam int REL   = 1000;
    localparam int RDLY  = 100;
    localparam int RPER  = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       key_en;
    logic [3:0] key_code;
    logic       held;
    logic [3:0] held_code;
    logic       overflow;
    logic       clr_ovf;
    logic [2:0] fifo_count;

    int vectors = 0;
    int miscompares = 0;

    key_event_ctrl_if evtIf ();

    key_event_ctrl #(
        .DEPTH          (DEPTH),
        .RELEASE_CYCLES (REL),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .key_en     (key_en),
        .key_code   (key_code),
        .evt        (evtIf),
        .held       (held),
        .held_code  (held_code),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_code = code;
        key_en   = 1'b1;
        tick(1);
        key_en   = 1'b0;
    endtask

    task automatic wait_release();
        int k = 0;
        while (held === 1'b1 && k < 2 * REL) begin
            tick(1);
            k++;
        end
        vectors++;
        if (held !== 1'b0) begin miscompares++; $display("[TB] FAIL release_wait: held=%0b required 0", held); end
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; key_en = 1'b0; key_code = 4'd0; clr_ovf = 1'b0;
        evtIf.evt_ready = 1'b0;
        tick(3);
        vectors++;
        if ({evtIf.evt_valid, evtIf.evt_code, held, held_code} !== 10'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_evt: valid/code/held/held_code=%b required 0", {evtIf.evt_valid, evtIf.evt_code, held, held_code});
        end
        vectors++;
        if ({overflow, fifo_count} !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_ovf_count: %b required 0", {overflow, fifo_count}); end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_press_hold();
        evtIf.evt_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            press(KEY_5);
            vectors++;
            if (held !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_held%0d: got %0b required 1", k, held); end
            if (k < 9) tick(799);
        end
        tick(REL - 1);
        vectors++;
        if (held !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_before_timeout: got %0b required 1", held); end
        tick(1);
        vectors++;
        if (held !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_at_timeout: got %0b required 0", held); end
        vectors++;
        if (fifo_count !== 3'd1) begin miscompares++; $display("[TB] FAIL hold_count: got %0d required 1", fifo_count); end
        vectors++;
        if (evtIf.evt_valid !== 1'b1 || evtIf.evt_code !== 4'd5) begin
            miscompares++; $display("[TB] FAIL hold_event: valid=%0b code=%0d required 1/5", evtIf.evt_valid, evtIf.evt_code);
        end
        evtIf.evt_ready = 1'b1;
        tick(1);
        evtIf.evt_ready = 1'b0;
        vectors++;
        if (evtIf.evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_drained: valid=%0b required 0", evtIf.evt_valid); end
    endtask

    task automatic test_rollover();
        evtIf.evt_ready = 1'b0;
        press(KEY_3);
        tick(799);
        press(KEY_7);
        vectors++;
        if (fifo_count !== 3'd2 || evtIf.evt_code !== 4'd3) begin
            miscompares++; $display("[TB] FAIL roll_first: count=%0d code=%0d required 2/3", fifo_count, evtIf.evt_code);
        end
        vectors++;
        if (held_code !== 4'd7) begin miscompares++; $display("[TB] FAIL roll_held_code: got %0d required 7", held_code); end
        evtIf.evt_ready = 1'b1;
        tick(1);
        vectors++;
        if (evtIf.evt_valid !== 1'b1 || evtIf.evt_code !== 4'd7) begin
            miscompares++; $display("[TB] FAIL roll_second: valid=%0b code=%0d required 1/7", evtIf.evt_valid, evtIf.evt_code);
        end
        tick(1);
        evtIf.evt_ready = 1'b0;
        vectors++;
        if (evtIf.evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL roll_empty: valid=%0b required 0", evtIf.evt_valid); end
        wait_release();
    endtask

    task automatic test_overflow();
        evtIf.evt_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            press(4'(c));
            wait_release();
        end
        vectors++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            miscompares++; $display("[TB] FAIL ovf_filled: count=%0d ovf=%0b required 4/0", fifo_count, overflow);
        end
        // Fifth press collides with a clear request: the set has priority.
        key_code = 4'd5; key_en = 1'b1; clr_ovf = 1'b1;
        tick(1);
        key_en = 1'b0; clr_ovf = 1'b0;
        vectors++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
            miscompares++; $display("[TB] FAIL ovf_set: ovf=%0b count=%0d required 1/4", overflow, fifo_count);
        end
        wait_release();
        evtIf.evt_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            vectors++;
            if (evtIf.evt_valid !== 1'b1 || evtIf.evt_code !== 4'(c)) begin
                miscompares++; $display("[TB] FAIL ovf_drain%0d: valid=%0b code=%0d required 1/%0d", c, evtIf.evt_valid, evtIf.evt_code, c);
            end
            tick(1);
        end
        evtIf.evt_ready = 1'b0;
        vectors++;
        if (evtIf.evt_valid !== 1'b0 || overflow !== 1'b1) begin
            miscompares++; $display("[TB] FAIL ovf_sticky: valid=%0b ovf=%0b required 0/1", evtIf.evt_valid, overflow);
        end
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_clear: got %0b required 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        evtIf.evt_ready = 1'b0;
        for (int c = 10; c <= 13; c++) begin
            press(4'(c));
            wait_release();
        end
        key_code = KEY_9; key_en = 1'b1; evtIf.evt_ready = 1'b1;
        tick(1);
        key_en = 1'b0; evtIf.evt_ready = 1'b0;
        vectors++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0 || evtIf.evt_code !== 4'd11) begin
            miscompares++;
            $display("[TB] FAIL full_pushpop: count=%0d ovf=%0b head=%0d required 4/0/11", fifo_count, overflow, evtIf.evt_code);
        end
        evtIf.evt_ready = 1'b1;
        tick(2);
        vectors++;
        if (evtIf.evt_code !== 4'd13) begin miscompares++; $display("[TB] FAIL full_third: got %0d required 13", evtIf.evt_code); end
        tick(1);
        vectors++;
        if (evtIf.evt_valid !== 1'b1 || evtIf.evt_code !== 4'd9 || fifo_count !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL full_last: valid=%0b code=%0d count=%0d required 1/9/1", evtIf.evt_valid, evtIf.evt_code, fifo_count);
        end
        tick(1);
        evtIf.evt_ready = 1'b0;
        wait_release();
    endtask

    task automatic test_flush();
        evtIf.evt_ready = 1'b0;
        press(KEY_6);
        wait_release();
        press(KEY_8);
        vectors++;
        if (fifo_count !== 3'd2) begin miscompares++; $display("[TB] FAIL flush_queued: count=%0d required 2", fifo_count); end
        enable = 1'b0; key_en = 1'b1; key_code = KEY_2;
        tick(1);
        enable = 1'b1; key_en = 1'b0;
        vectors++;
        if ({evtIf.evt_valid, fifo_count, held} !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL flush_state: valid=%0b count=%0d held=%0b required 0/0/0", evtIf.evt_valid, fifo_count, held);
        end
        press(KEY_8);
        vectors++;
        if (evtIf.evt_valid !== 1'b1 || evtIf.evt_code !== 4'd8 || fifo_count !== 3'd1 || held !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_repress: valid=%0b code=%0d count=%0d held=%0b required 1/8/1/1", evtIf.evt_valid, evtIf.evt_code, fifo_count, held);
        end
        evtIf.evt_ready = 1'b1;
        tick(1);
        evtIf.evt_ready = 1'b0;
        wait_release();
    endtask

    task automatic test_repeat();
        int seen[$];
        int want[$];
`ifdef KEY_REPEAT_EN
        want = '{1, 101, 151, 201, 251};
`else
        want = '{1};
`endif
        evtIf.evt_ready = 1'b1;
        key_code = KEY_C;
        for (int i = 0; i < 300; i++) begin
            key_en = (i % 20 == 0);
            tick(1);
            if (evtIf.evt_valid === 1'b1) seen.push_back(i + 1);
        end
        key_en = 1'b0;
        vectors++;
        if (seen.size() != want.size()) begin
            miscompares++; $display("[TB] FAIL repeat_count: got %0d events required %0d", seen.size(), want.size());
        end
        for (int j = 0; j < seen.size() && j < want.size(); j++) begin
            vectors++;
            if (seen[j] != want[j]) begin
                miscompares++; $display("[TB] FAIL repeat_cycle%0d: got %0d required %0d", j, seen[j], want[j]);
            end
        end
        wait_release();
        tick(2);
        evtIf.evt_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        press(KEY_4);
        #3;
        rst = 1'b0;
        #1;
        vectors++;
        if ({evtIf.evt_valid, held, held_code, fifo_count} !== 9'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: valid=%0b held=%0b code=%0d count=%0d required 0", evtIf.evt_valid, held, held_code, fifo_count);
        end
        #1;
        rst = 1'b1;
        tick(2);
    endtask

    initial begin
        #(60000 * 10);
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_press_hold();
        test_rollover();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_repeat();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Sits between the 4x4 keypad scanner and the whack-a-mole game FSM.
- Turns the scanner's repeated per-scan strobes into one press event per physical press, and detects release by timeout.
- Queues events in a small FIFO and delivers them to the game logic over a valid/ready handshake.
- The game can gate key input, flush pending events, and monitor the held key and overflow.

Parameters:
- DEPTH, 4: event FIFO entries; power of two, at least 2.
- RELEASE_CYCLES, 250000: idle clk cycles with no key_en before a key counts as released (5 ms at 50 MHz; one full scan is 4 ms).
- REPEAT_DELAY, 25000000: hold cycles before the first auto-repeat (KEY_REPEAT_EN only).
- REPEAT_PERIOD, 10000000: cycles between auto-repeats (KEY_REPEAT_EN only).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous reset, active-low.
- enable, input, 1: accept key input; low flushes the FIFO and forces IDLE.
- key_en, input, 1: scanner strobe, one cycle, code valid.
- key_code, input, 4: scanner key code (0-9, A-D = 10-13, # = 14, * = 15).
- evt_valid, output, 1: FIFO head valid.
- evt_code, output, 4: FIFO head key code.
- evt_ready, input, 1: consumer pops the head when evt_valid && evt_ready.
- held, output, 1: a key is currently down (state PRESSED).
- held_code, output, 4: code of the held key.
- overflow, output, 1: sticky; an event was dropped because the FIFO was full.
- clr_ovf, input, 1: clears overflow.
- fifo_count, output, $clog2(DEPTH)+1: occupancy.

Behaviour:
- Reset values: evt_valid=0, evt_code=0, held=0, held_code=0, overflow=0, fifo_count=0, state=IDLE, release timer=0.
- All outputs are registered. A push into an empty FIFO gives evt_valid=1 on the next cycle (1-cycle latency). evt_code is stable while evt_valid && !evt_ready.
- State machine, IDLE:
  - key_en → push key_code, latch held_code, clear timer, go to PRESSED.
- State machine, PRESSED:
  - key_en with the same code → clear timer, no push.
  - key_en with a different code → push the new code, latch it, clear timer (rollover press).
  - No key_en and timer == RELEASE_CYCLES-1 → go to IDLE, held=0.
  - Otherwise → timer increments. The timer saturates; it never wraps.
- enable low (synchronous):
  - FIFO emptied, state forced to IDLE, timer cleared, key_en ignored.
  - overflow is retained.
  - On re-enable, the first key_en is treated as a fresh press.
- FIFO:
  - Circular buffer with wrap-around read/write pointers and an explicit count.
  - Push when full and no pop in the same cycle → event dropped, overflow set to 1 next cycle, contents unchanged.
  - Push and pop in the same cycle when full → both succeed, count unchanged.
  - Push and pop in the same cycle when empty → not possible; evt_valid=0, so no pop occurs and the push lands.
  - evt_ready while empty → ignored.
- clr_ovf and an overflow in the same cycle → the set wins; overflow stays 1.
- Reset asserted mid-operation → all state returns to reset values immediately and asynchronously.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In PRESSED, a hold counter starts at the press.
  - When the counter reaches REPEAT_DELAY, held_code is pushed again; further pushes follow every REPEAT_PERIOD cycles while the key stays held.
  - Repeat pushes obey the same full/overflow rules.
  - The counter clears on release, on a rollover press, and when enable is low.
- Undefined: no hold counter is built; exactly one event per press.

Decomposition:
- Package key_evt_pkg:
  - Key code constants: KEY_0..KEY_9, KEY_A=10, KEY_B=11, KEY_C=12, KEY_D=13, KEY_HASH=14, KEY_STAR=15.
  - State enum {IDLE, PRESSED}.
  - Counter width function.
- Sub-module key_evt_fifo:
  - Parameterised DEPTH×4-bit FIFO with push/pop/flush, full/empty and count.
  - Instanced once.

Test Plan:
- Press and hold: key_en code 5 every 200000 cycles, 10 times, then stop → exactly one event (5); held=1 throughout; held=0 at 250000 cycles after the last strobe.
- Rollover: code 3, then code 7 after 200000 cycles → events 3 then 7, in that order; held_code=7.
- Overflow: evt_ready=0; press codes 1, 2, 3, 4, 5, each separated by a release → fifo_count=4, overflow=1, then drain gives 1, 2, 3, 4. Pulse clr_ovf → overflow=0.
- Full push+pop: FIFO full, evt_ready=1 in the same cycle as a new press of code 9 → count stays 4; 9 is the last entry.
- Flush: 2 events queued, enable=0 for 1 cycle → evt_valid=0, fifo_count=0, held=0; the next key_en after re-enable produces an event.
- KEY_REPEAT_EN build with REPEAT_DELAY=100, REPEAT_PERIOD=50, RELEASE_CYCLES=1000: hold code 12 for 300 cycles (strobe every 20 cycles) → events at cycles 1, 101, 151, 201, 251; zero repeats in a build without the macro.
